// File: rtl/vcpop_seq.sv
// vcpop.m sequencer: reads mask/v0 chunks, masks tail and inactive bits, feeds the
// external popcount pipeline and accumulates the returned per-chunk counts.
module vcpop_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int VLEN       = 512,
  parameter int VL_WIDTH   = 10,
  parameter int CHUNK_AW   = 3,
  parameter int POP_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VL_WIDTH-1:0]   req_vl,
  input  logic                  req_vm,
  output logic                  mrd_en,
  output logic [CHUNK_AW-1:0]   mrd_addr,
  input  logic [DATA_WIDTH-1:0] mrd_data,
  input  logic [DATA_WIDTH-1:0] mrd_v0,
  output logic [DATA_WIDTH-1:0] pop_m0,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_count,
  input  logic [DATA_WIDTH-1:0] pop_result,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  resp_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned DW_SH = $clog2(DATA_WIDTH);

  state_t                state;
  logic [VL_WIDTH-1:0]   vl_q, acc, vl_eff, rem;
  logic                  vm_q;
  logic [CHUNK_AW-1:0]   rd_idx, last_idx, rd_chunk;
  logic                  rd_v, pv_q;
  logic [DATA_WIDTH-1:0] m0_q, tail, masked;
  logic [POP_LAT-1:0]    sr;
  logic                  pending;

  assign vl_eff  = (req_vl > VL_WIDTH'(VLEN)) ? VL_WIDTH'(VLEN) : req_vl;
  assign rem     = vl_q - (VL_WIDTH'(rd_chunk) << DW_SH);
  assign pending = rd_v || pv_q || (|sr);

  // Bits at or beyond vl within the returning chunk are forced to zero.
  always_comb begin
    tail = '0;
    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
      tail[j] = (j < 32'(rem));
    end
  end

  assign masked = mrd_data & tail & (vm_q ? {DATA_WIDTH{1'b1}} : mrd_v0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      vl_q     <= '0;
      vm_q     <= 1'b0;
      acc      <= '0;
      rd_idx   <= '0;
      last_idx <= '0;
      rd_chunk <= '0;
      rd_v     <= 1'b0;
      pv_q     <= 1'b0;
      m0_q     <= '0;
      sr       <= '0;
    end else begin
      rd_v     <= (state == READ);
      rd_chunk <= rd_idx;
      pv_q     <= rd_v;
      m0_q     <= rd_v ? masked : '0;
      sr       <= (sr << 1) | POP_LAT'(pv_q);
      if (sr[POP_LAT-1]) acc <= acc + pop_result[VL_WIDTH-1:0];
      case (state)
        IDLE: begin
          if (req_valid) begin
            vl_q     <= vl_eff;
            vm_q     <= req_vm;
            last_idx <= CHUNK_AW'((vl_eff - 1'b1) >> DW_SH);
            rd_idx   <= '0;
            acc      <= '0;
            state    <= (vl_eff == '0) ? RESP : READ;
          end
        end
        READ: begin
          rd_idx <= rd_idx + 1'b1;
          if (rd_idx == last_idx) state <= DRAIN;
        end
        DRAIN: if (!pending) state <= RESP;
        RESP:  if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so everything reads zero while rst is low.
  assign req_ready  = rst && (state == IDLE);
  assign mrd_en     = rst && (state == READ);
  assign mrd_addr   = mrd_en ? rd_idx : '0;
  assign pop_valid  = rst && pv_q;
  assign pop_m0     = rst ? m0_q : '0;
  assign pop_count  = '0;
  assign resp_valid = rst && (state == RESP);
  assign resp_data  = resp_valid ? {{(DATA_WIDTH-VL_WIDTH){1'b0}}, acc} : '0;

endmodule

// File: tb/tb_vcpop_seq.sv
// Directed bench for vcpop_seq with behavioural mask memory and popcount pipeline models.
module tb_vcpop_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_vm;
  logic [9:0]  req_vl;
  logic        mrd_en;
  logic [2:0]  mrd_addr;
  logic [63:0] mrd_data, mrd_v0, pop_m0, pop_count, pop_result, resp_data;
  logic        pop_valid, resp_valid, resp_ready;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [8];
  logic [63:0] v0m [8];
  logic [63:0] pm  [8];
  logic [63:0] p1, p2, p3;

  always #5 clk = ~clk;

  vcpop_seq #(
    .DATA_WIDTH(64), .VLEN(512), .VL_WIDTH(10), .CHUNK_AW(3), .POP_LAT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl), .req_vm(req_vm),
    .mrd_en(mrd_en), .mrd_addr(mrd_addr), .mrd_data(mrd_data), .mrd_v0(mrd_v0),
    .pop_m0(pop_m0), .pop_valid(pop_valid), .pop_count(pop_count), .pop_result(pop_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  // Mask read port: one-cycle latency, junk when not reading.
  always @(posedge clk) begin
    mrd_data <= mrd_en ? mem[mrd_addr] : {$urandom, $urandom};
    mrd_v0   <= mrd_en ? v0m[mrd_addr] : {$urandom, $urandom};
  end

  // Three-stage popcount pipeline; non-valid slots carry a junk value.
  always @(posedge clk) begin
    p1 <= pop_valid ? 64'($countones(pop_m0)) : 64'h1234;
    p2 <= p1;
    p3 <= p2;
  end
  assign pop_result = p3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic run(input int vl, input logic vm, input int exp_cyc, input int exp_data,
                     input int exp_reads, input int hold);
    int nreads, npop, cyc;
    logic found;
    nreads = 0; npop = 0; cyc = 0; found = 1'b0;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_vl = 10'(vl); req_vm = vm; resp_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_vl = '1; req_vm = ~vm; end
      if (mrd_en) begin
        chk("mrd_addr", 64'(mrd_addr), 64'(nreads));
        nreads++;
      end
      if (pop_valid && npop < 8) begin pm[npop] = pop_m0; npop++; end
      if (resp_valid) begin found = 1'b1; cyc = c; end
    end
    chk("resp_seen", 64'(found), 64'd1);
    chk("resp_cycle", 64'(cyc), 64'(exp_cyc));
    chk("resp_data", resp_data, 64'(exp_data));
    chk("read_count", 64'(nreads), 64'(exp_reads));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", resp_data, 64'(exp_data));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 8; i++) begin
      mem[i] = '1;
      v0m[i] = 64'hAAAA_AAAA_AAAA_AAAA;
      pm[i]  = '0;
    end
    rst = 1'b0; req_valid = 1'b0; req_vl = '0; req_vm = 1'b1; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({req_ready, mrd_en, pop_valid, resp_valid}), 64'd0);
    chk("reset_data", resp_data | pop_m0, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_outs", 64'({mrd_en, pop_valid, resp_valid, mrd_addr}), 64'd0);
    chk("pop_count", pop_count, 64'd0);

    run(0, 1'b1, 1, 0, 0, 0);
    run(64, 1'b1, 8, 64, 1, 0);
    run(100, 1'b1, 9, 100, 2, 0);
    chk("vl100_chunk0", pm[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("vl100_chunk1", pm[1], 64'h0000_000F_FFFF_FFFF);
    run(512, 1'b0, 15, 256, 8, 0);
    chk("vm0_chunk3", pm[3], 64'hAAAA_AAAA_AAAA_AAAA);

    v0m[0] = 64'h0000_0000_0000_00FF;
    v0m[1] = '1;
    run(70, 1'b0, 9, 14, 2, 0);
    chk("vl70_chunk1", pm[1], 64'h0000_0000_0000_003F);
    v0m[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    v0m[1] = 64'hAAAA_AAAA_AAAA_AAAA;

    run(700, 1'b1, 15, 512, 8, 0);
    run(64, 1'b1, 8, 64, 1, 5);
    run(64, 1'b1, 8, 64, 1, 0);

    // Abort a full-length request partway through its reads.
    chk("abort_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_vl = 10'd512; req_vm = 1'b1;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_read", 64'(mrd_en), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_ctrl", 64'({req_ready, mrd_en, pop_valid, resp_valid, mrd_addr}), 64'd0);
    chk("abort_data", resp_data | pop_m0, 64'd0);
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp_valid || mrd_en) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    run(64, 1'b1, 8, 64, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcpop_seq.md
# vcpop_seq

Sequencer and accumulator for the vector mask population count (`vcpop.m`).
- Accepts a request carrying `vl` and `vm`.
- Reads the source mask register and `v0` from the mask read port in `DATA_WIDTH`-bit chunks.
- Zeroes tail and inactive bits, then streams the masked chunks into the downstream pipelined popcount stage, one per cycle.
- Sums the per-chunk counts that return after `POP_LAT` cycles and returns the scalar total over a valid/ready response port to the scalar writeback path.

## Interface

Parameters:
- `DATA_WIDTH`, 64: mask chunk width; also the width of the popcount stage data and of the result.
- `VLEN`, 512: mask register length in bits; must be a multiple of `DATA_WIDTH`.
- `VL_WIDTH`, 10: width of `vl`, equal to clog2(`VLEN`)+1.
- `CHUNK_AW`, 3: chunk address width, equal to clog2(`VLEN`/`DATA_WIDTH`).
- `POP_LAT`, 3: cycles from `pop_valid` to `pop_result` in the popcount stage.

Ports:
- `clk`  in  1  the single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `req_vl`  in  `VL_WIDTH`  number of elements counted.
- `req_vm`  in  1  1 = unmasked; 0 = only bits with `v0` set count.
- `mrd_en`  out  1  mask read strobe.
- `mrd_addr`  out  `CHUNK_AW`  chunk index.
- `mrd_data`  in  `DATA_WIDTH`  source mask chunk, valid the cycle after `mrd_en`.
- `mrd_v0`  in  `DATA_WIDTH`  `v0` chunk at the same index, same timing as `mrd_data`.
- `pop_m0`  out  `DATA_WIDTH`  masked chunk sent to the popcount stage.
- `pop_valid`  out  1  chunk valid.
- `pop_count`  out  `DATA_WIDTH`  carry-in count; tied to 0.
- `pop_result`  in  `DATA_WIDTH`  popcount of the chunk, `POP_LAT` cycles after `pop_valid`.
- `resp_valid`  out  1  result valid.
- `resp_data`  out  `DATA_WIDTH`  total count, zero-extended.
- `resp_ready`  in  1  result consumed when `resp_valid` and `resp_ready` are both high.

## Operation

States:
- **IDLE**: `req_ready`=1; all other outputs 0.
- **READ**: issues chunk reads in order.
- **DRAIN**: waits for outstanding popcount results.
- **RESP**: holds the result until it is consumed.

Transitions:
- IDLE→READ on accept with effective `vl`>0, where effective vl = min(`req_vl`, `VLEN`).
- IDLE→RESP on accept with effective `vl`=0; `resp_data`=0.
- READ→DRAIN after the last of N reads, where N = ceil(vl/`DATA_WIDTH`). Reads use `mrd_en`=1 and `mrd_addr`=0..N-1 on consecutive cycles.
- DRAIN→RESP once the final `pop_result` has been accumulated.
- RESP→IDLE on the response handshake.

Datapath rules:
- **Chunk masking**: bit j of chunk c is passed iff c·`DATA_WIDTH`+j < vl and (`req_vm` or `mrd_v0`[j]). All other bits are forced to 0. The masked chunk is registered onto `pop_m0` with `pop_valid`=1 the cycle after data return.
- **Result tracking**: a `POP_LAT`-deep valid shift register tracks in-flight chunks. `pop_result` is added into a `VL_WIDTH`-bit accumulator only when the matching tap is set. The accumulator is cleared on accept.
- **Overflow**: none possible, since the total is ≤ `VLEN`.
- **Latched request fields**: `vl` and `vm` are latched on accept. Input changes after accept are ignored.

Reset:
- While `rst`=0: state IDLE, accumulator and shift register cleared, and every output is 0, including `req_ready`.
- Reset mid-operation aborts the request. In-flight results are discarded and no response is produced.

## Timing

All cycle numbers are relative to the accept edge (cycle 0).
- Read i is issued in cycle 1+i, for i = 0..N-1.
- Data for read i returns in cycle 2+i.
- `pop_valid` for chunk i is high in cycle 3+i.
- `pop_result` for chunk i is sampled in cycle 3+i+`POP_LAT`.
- `resp_valid` rises in cycle N+4+`POP_LAT`, which is N+7 for the default `POP_LAT`=3.
- If effective `vl`=0, `resp_valid` rises in cycle 1.
- `resp_valid` and `resp_data` are stable until the handshake; `resp_valid` drops the following cycle.
- `req_ready` is 1 only in IDLE. A new request is accepted at the earliest 1 cycle after the response handshake.
- Throughput is one chunk per cycle; there is no backpressure from the popcount stage.

## Test plan

- `vl`=0, `vm`=1 → `resp_valid` in cycle 1, `resp_data`=0, no `mrd_en` pulses.
- `vl`=64, `vm`=1, chunk 0 = all ones → one read at addr 0, `resp_data`=64 in cycle 8.
- `vl`=100, `vm`=1, both chunks all ones → `pop_m0` of chunk 1 = 0x0000_000F_FFFF_FFFF, `resp_data`=100 in cycle 9.
- `vl`=512, `vm`=0, mask all ones, `v0`=0xAAAA_AAAA_AAAA_AAAA for all chunks → `resp_data`=256 in cycle 15.
- `vl`=64 with `resp_ready`=0 for 5 cycles → `resp_valid` and `resp_data` held stable and `req_ready`=0 throughout; the next request is accepted one cycle after the handshake.
- `rst`=0 for one cycle in the middle of READ of a `vl`=512 request → all outputs 0 and no response; a following `vl`=64 all-ones request returns 64.
